// File: rtl/reshape_maxpool_engine.sv
// reshape_maxpool_engine: 2x2 stride-2 lane-wise max-pool over a raster (row, col, group) beat stream
module reshape_maxpool_engine #(
  parameter int DATA_W     = 128,
  parameter int LANE_W     = 8,
  parameter int HBUF_DEPTH = 64,
  parameter int VBUF_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Control_RE,
  output logic [3:0]        State_RE,
  input  logic [31:0]       Reg_7,
  input  logic [DATA_W-1:0] S_Data,
  input  logic              S_Valid,
  output logic              S_Ready,
  output logic [DATA_W-1:0] M_Data,
  output logic              M_Valid,
  input  logic              M_Ready,
  output logic              DMA_Read_Start,
  output logic              DMA_Write_Start
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int HA = $clog2(HBUF_DEPTH);
  localparam int VA = $clog2(VBUF_DEPTH);
  typedef enum logic [3:0] {IDLE = 4'b0000, RUN = 4'b0001, DONE = 4'b1111} state_t;
  state_t state, state_nx;
  logic [15:0] w_q, r, c, we_m1;
  logic [HA-1:0] g, g_last;
  logic [VA-1:0] vptr;
  logic in_done, out_done, m_last;
  logic start, empty, odd, accept, g_end, c_end, in_fin, out_fin, pool_last;
  logic [DATA_W-1:0] hbuf [HBUF_DEPTH];
  logic [DATA_W-1:0] vbuf [VBUF_DEPTH];
  logic [DATA_W-1:0] mx2, mx3;
  assign State_RE = state;
  assign start = state == IDLE && Control_RE == 4'b0100;
  assign empty = Reg_7[15:0] == 16'd0 || Reg_7[31:16] == 16'd0;
  assign DMA_Read_Start = rst && start && !empty;
  assign DMA_Write_Start = rst && start && !empty;
  assign odd = c[0] & r[0];
  assign S_Ready = state == RUN && !in_done && (!odd || !M_Valid || M_Ready);
  assign accept = S_Valid && S_Ready;
  assign g_end = g == g_last;
  assign c_end = c == w_q - 16'd1;
  assign in_fin = accept && g_end && c_end && r == w_q - 16'd1;
  // Last pooled position ignores the trailing column/row of an odd width
  assign we_m1 = {w_q[15:1], 1'b0} - 16'd1;
  assign pool_last = g_end && c == we_m1 && r == we_m1;
  assign out_fin = M_Valid && M_Ready && m_last;
  always_comb begin
    mx2 = '0;
    mx3 = '0;
    for (int i = 0; i < LANES; i++) begin
      mx2[i*LANE_W +: LANE_W] = hbuf[g][i*LANE_W +: LANE_W] > S_Data[i*LANE_W +: LANE_W] ?
                                hbuf[g][i*LANE_W +: LANE_W] : S_Data[i*LANE_W +: LANE_W];
      mx3[i*LANE_W +: LANE_W] = vbuf[vptr][i*LANE_W +: LANE_W] > mx2[i*LANE_W +: LANE_W] ?
                                vbuf[vptr][i*LANE_W +: LANE_W] : mx2[i*LANE_W +: LANE_W];
    end
  end
  always_comb begin
    state_nx = state;
    if (start) state_nx = empty ? DONE : RUN;
    else if (state == RUN && (in_done || in_fin) && (out_done || out_fin)) state_nx = DONE;
    else if (state == DONE && Control_RE == 4'b1111) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_q <= '0;
      g_last <= '0;
      g <= '0;
      c <= '0;
      r <= '0;
      vptr <= '0;
      in_done <= 1'b0;
      out_done <= 1'b0;
      m_last <= 1'b0;
      M_Valid <= 1'b0;
      M_Data <= '0;
    end else begin
      if (start) begin
        w_q <= Reg_7[15:0];
        g_last <= HA'({Reg_7[31:16], 1'b0} - 17'd1);
        g <= '0;
        c <= '0;
        r <= '0;
        vptr <= '0;
        in_done <= 1'b0;
        out_done <= Reg_7[15:1] == 15'd0;
      end else if (accept) begin
        g <= g_end ? '0 : g + 1'b1;
        if (g_end) begin
          c <= c_end ? 16'd0 : c + 16'd1;
          r <= c_end ? r + 16'd1 : r;
        end
        vptr <= (g_end && c_end) ? '0 : c[0] ? vptr + 1'b1 : vptr;
        in_done <= in_fin;
      end
      if (out_fin) out_done <= 1'b1;
      if (accept && odd) begin
        M_Data <= mx3;
        M_Valid <= 1'b1;
        m_last <= pool_last;
      end else if (M_Ready) M_Valid <= 1'b0;
    end
  always_ff @(posedge clk)
    if (accept) begin
      if (!c[0]) hbuf[g] <= S_Data;
      else if (!r[0]) vbuf[vptr] <= mx2;
    end
endmodule

// File: tb/tb_reshape_maxpool_engine.sv
// tb_reshape_maxpool_engine: randomized scoreboard bench against a direct 2x2 window max model
module tb_reshape_maxpool_engine;
  logic clk = 0, rst = 0;
  logic [3:0] Control_RE = 0, State_RE;
  logic [31:0] Reg_7 = 0;
  logic [127:0] S_Data = 0, M_Data;
  logic S_Valid = 0, S_Ready, M_Valid, M_Ready = 1, DMA_Read_Start, DMA_Write_Start;
  int checks = 0, errors = 0;
  logic [127:0] exp_q[$];
  int in_idx = 0, in_tot = 0, cur_w = 1, cur_g = 1, outs = 0, dma_rd = 0, dma_wr = 0;
  bit chk_rdy = 0, rnd_ready = 0;

  reshape_maxpool_engine dut (
    .clk(clk), .rst(rst), .Control_RE(Control_RE), .State_RE(State_RE), .Reg_7(Reg_7),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
    .DMA_Read_Start(DMA_Read_Start), .DMA_Write_Start(DMA_Write_Start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    M_Ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pops, input-ready rule, pulse and beat counts
  always @(negedge clk) begin
    int c, r;
    bit oo;
    if (DMA_Read_Start) dma_rd++;
    if (DMA_Write_Start) dma_wr++;
    if (M_Valid && M_Ready) begin
      outs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_beat: unexpected beat %0h, none expected", M_Data);
      end else chk("out_beat", M_Data, exp_q.pop_front());
    end
    if (chk_rdy && State_RE == 4'b0001 && cur_g > 0 && cur_w > 0) begin
      c = (in_idx / cur_g) % cur_w;
      r = in_idx / (cur_g * cur_w);
      oo = in_idx < in_tot && c % 2 == 1 && r % 2 == 1;
      chk("s_ready", S_Ready, (in_idx < in_tot) && !(oo && M_Valid && !M_Ready));
    end
    if (S_Valid && S_Ready) in_idx++;
  end

  task automatic run(input logic [31:0] reg7, input bit rnd_data, input int abort_at,
                     input bit poke, input int hold);
    int w, g, pw, t, rd0, wr0;
    bit live;
    logic [127:0] beats[$];
    logic [127:0] e, b;
    logic [7:0] m, v;
    w = int'(reg7[15:0]);
    g = 2 * int'(reg7[31:16]);
    pw = w / 2;
    live = w * g != 0;
    for (int i = 0; i < w * w * g; i++)
      beats.push_back(rnd_data ? {$urandom, $urandom, $urandom, $urandom} : {16{8'(i)}});
    for (int pr = 0; pr < pw; pr++)
      for (int pc = 0; pc < pw; pc++)
        for (int gg = 0; gg < g; gg++) begin
          for (int l = 0; l < 16; l++) begin
            m = 0;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                b = beats[((2 * pr + dr) * w + 2 * pc + dc) * g + gg];
                v = b[l*8 +: 8];
                if (v > m) m = v;
              end
            e[l*8 +: 8] = m;
          end
          exp_q.push_back(e);
        end
    cur_w = w;
    cur_g = g;
    in_tot = w * w * g;
    in_idx = 0;
    outs = 0;
    rd0 = dma_rd;
    wr0 = dma_wr;
    Reg_7 = reg7;
    @(posedge clk);
    #1;
    Control_RE = 4'b0100;
    @(negedge clk);
    chk("dma_read_pulse", DMA_Read_Start, live);
    chk("dma_write_pulse", DMA_Write_Start, live);
    @(posedge clk);
    #1;
    Control_RE = 0;
    chk("state_after_start", State_RE, live ? 4'b0001 : 4'b1111);
    if (poke) begin
      Control_RE = 4'b0100;
      @(posedge clk);
      #1;
      Control_RE = 0;
      chk("state_start_ignored", State_RE, 4'b0001);
    end
    chk_rdy = 1;
    for (int i = 0; i < beats.size(); i++) begin
      if (i == abort_at) begin
        S_Valid = 0;
        rst = 0;
        #2;
        chk("abort_state", State_RE, 0);
        chk("abort_m_valid", M_Valid, 0);
        chk("abort_m_data", M_Data, 0);
        chk("abort_s_ready", S_Ready, 0);
        chk("abort_dma", {DMA_Read_Start, DMA_Write_Start}, 0);
        exp_q.delete();
        chk_rdy = 0;
        @(posedge clk);
        #1;
        rst = 1;
        return;
      end
      S_Data = beats[i];
      S_Valid = 1;
      t = 0;
      @(negedge clk);
      while (!S_Ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        checks++;
        errors++;
        $display("FAIL input_stall: beat %0d never accepted", i);
        break;
      end
      @(posedge clk);
      #1;
    end
    S_Valid = 0;
    t = 0;
    while (State_RE != 4'b1111 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk_rdy = 0;
    chk("done_reached", State_RE, 4'b1111);
    chk("out_count", outs, pw * pw * g);
    chk("in_count", in_idx, w * w * g);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("dma_read_count", dma_rd - rd0, live);
    chk("dma_write_count", dma_wr - wr0, live);
    exp_q.delete();
    repeat (hold) @(negedge clk);
    chk("done_held", State_RE, 4'b1111);
    @(posedge clk);
    #1;
    Control_RE = 4'b1111;
    @(posedge clk);
    #1;
    Control_RE = 0;
    chk("idle_after_ack", State_RE, 0);
  endtask

  initial begin
    #12;
    chk("rst_state", State_RE, 0);
    chk("rst_s_ready", S_Ready, 0);
    chk("rst_m_valid", M_Valid, 0);
    chk("rst_m_data", M_Data, 0);
    chk("rst_dma", {DMA_Read_Start, DMA_Write_Start}, 0);
    @(posedge clk);
    #1;
    rst = 1;
    run(32'h0001_0004, 0, -1, 0, 2);
    rnd_ready = 1;
    run(32'h0001_0004, 0, -1, 0, 2);
    run(32'h0001_0005, 1, -1, 0, 2);
    run(32'h0004_0007, 1, -1, 0, 2);
    rnd_ready = 0;
    run(32'h0010_001A, 1, -1, 0, 2);
    run(32'h0010_001A, 1, 10, 0, 0);
    run(32'h0001_0004, 0, -1, 0, 2);
    rnd_ready = 1;
    run(32'h0001_0001, 1, -1, 0, 2);
    run(32'h0003_0006, 1, -1, 1, 100);
    run(32'h0000_0004, 0, -1, 0, 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "timeout");
  end
endmodule
